// File: rtl/circ_rot_aligner_if.sv
// Job/result handshake bundle for circ_rot_aligner: the source side is the master,
// the aligner is the slave.
interface circ_rot_aligner_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_seq;
  logic [N-1:0]  pattern;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  aligned;
  logic [CW-1:0] rot_amt;
  logic          found;

  modport master (
    output in_valid, in_seq, pattern, out_ready,
    input  in_ready, out_valid, aligned, rot_amt, found
  );

  modport slave (
    input  in_valid, in_seq, pattern, out_ready,
    output in_ready, out_valid, aligned, rot_amt, found
  );
endinterface

// File: rtl/circ_rot_aligner.sv
// Sequential rotation aligner: rotates the captured word right one bit per cycle
// until it equals the reference pattern, then reports the rotation count.
module circ_rot_aligner #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst_n,
  circ_rot_aligner_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  work, pat, orig, aligned_q;
  logic [CW-1:0] cnt, rot_q;
  logic          found_q;
  logic          match, last;

  assign match = (work == pat);
  assign last  = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = SEARCH;
      SEARCH:  if (match || last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = rst_n && (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // The first matching count wins, so periodic words report the smallest rotation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work      <= '0;
      pat       <= '0;
      orig      <= '0;
      cnt       <= '0;
      aligned_q <= '0;
      rot_q     <= '0;
      found_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.in_seq;
            orig <= bus.in_seq;
            pat  <= bus.pattern;
            cnt  <= '0;
          end
        end
        SEARCH: begin
          if (match) begin
            aligned_q <= work;
            rot_q     <= cnt;
            found_q   <= 1'b1;
          end else if (!last) begin
            work <= {work[0], work[N-1:1]};
            cnt  <= cnt + CW'(1);
          end else begin
            aligned_q <= orig;
            rot_q     <= '0;
            found_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.aligned = aligned_q;
  assign bus.rot_amt = rot_q;
  assign bus.found   = found_q;
endmodule

// File: tb/tb_circ_rot_aligner.sv
// Directed scoreboard bench for circ_rot_aligner: expected results are queued at
// the input handshake and checked when the result is presented.
module tb_circ_rot_aligner;
  localparam int N = 8;

  typedef struct {
    logic [7:0] aligned;
    logic [2:0] rot;
    logic       found;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  circ_rot_aligner_if #(.N(N)) bus ();

  circ_rot_aligner #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic give_up(input string tag);
    fails++;
    $display("FAIL %s timed out", tag);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic check_result(input string tag, input exp_t e);
    chk({tag, "_valid"},   {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_aligned"}, {24'd0, bus.aligned},   {24'd0, e.aligned});
    chk({tag, "_rot"},     {29'd0, bus.rot_amt},   {29'd0, e.rot});
    chk({tag, "_found"},   {31'd0, bus.found},     {31'd0, e.found});
    chk({tag, "_inrdy"},   {31'd0, bus.in_ready},  32'd0);
  endtask

  // Offer a job, wait for the result, optionally stall the sink while junk is
  // offered at the input, then accept and confirm return to IDLE.
  task automatic run_job(input string tag, input logic [7:0] seq, input logic [7:0] pat,
                         input logic [7:0] ex_al, input logic [2:0] ex_rot,
                         input logic ex_fnd, input int ex_lat, input int hold);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_seq    = seq;
    bus.pattern   = pat;
    bus.out_ready = (hold == 0);
    e.aligned = ex_al; e.rot = ex_rot; e.found = ex_fnd; e.lat = ex_lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
      if (lat > 3 * N) give_up({tag, "_latency"});
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, lat, e.lat);
    check_result(tag, e);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = h[0] ? 1'b0 : 1'b1;
      bus.in_seq   = 8'hFF;
      bus.pattern  = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      check_result({tag, "_hold"}, e);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_post_rdy"},   {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_seq    = '0;
    bus.pattern   = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   {31'd0, bus.out_valid}, 32'd0);
    chk("rst_inrdy",   {31'd0, bus.in_ready},  32'd0);
    chk("rst_aligned", {24'd0, bus.aligned},   32'd0);
    chk("rst_rot",     {29'd0, bus.rot_amt},   32'd0);
    chk("rst_found",   {31'd0, bus.found},     32'd0);
    rst_n = 1'b1;

    run_job("t1_basic",    8'hA5, 8'hB4, 8'hB4, 3'd3, 1'b1, 4, 0);
    run_job("t2_zero",     8'h3C, 8'h3C, 8'h3C, 3'd0, 1'b1, 1, 0);
    run_job("t3_periodic", 8'h55, 8'hAA, 8'hAA, 3'd1, 1'b1, 2, 0);
    run_job("t4_miss",     8'h01, 8'h03, 8'h01, 3'd0, 1'b0, 8, 0);
    run_job("t5_bp",       8'hA5, 8'hB4, 8'hB4, 3'd3, 1'b1, 4, 5);
    run_job("t5_ones",     8'hFF, 8'hFF, 8'hFF, 3'd0, 1'b1, 1, 0);

    // Reset two cycles into a miss search; its result must never appear.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_seq   = 8'h01;
    bus.pattern  = 8'h03;
    e_abort();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_inrdy", {31'd0, bus.in_ready},  32'd0);
    chk("t6_rst_found", {31'd0, bus.found},     32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_idle_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("t6_idle_rdy",   {31'd0, bus.in_ready},  32'd1);
    end
    run_job("t6_new", 8'h80, 8'h01, 8'h01, 3'd7, 1'b1, 8, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic e_abort();
    exp_t e;
    e.aligned = 8'h01; e.rot = 3'd0; e.found = 1'b0; e.lat = N;
    sb.push_back(e);
  endtask
endmodule
